axi4_mem_slave_fsm: RTL and testbench
=====================================

Name: axi4_mem_slave_fsm

Overview:
AXI4 slave front end that sits directly upstream of the word-addressed single-port memory. It accepts AXI4 INCR write and read bursts on the AW/W/B and AR/R channels and converts each beat into one mem_en/mem_we/mem_addr/mem_wdata request. It returns memory read data on the R channel with full RREADY backpressure. One burst is in flight at a time.

Parameters:
DATA_WIDTH, 32, AXI data and memory word width in bits (power of 2, at least 8)
ADDR_WIDTH, 16, AXI byte address width
MEMORY_DEPTH, 1024, number of memory words
MEM_ADDR_WIDTH, $clog2(MEMORY_DEPTH), memory word-index width

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETn  in  1  reset, synchronous, active-low
AWADDR  in  ADDR_WIDTH  write burst start byte address
AWLEN  in  8  beats minus 1
AWSIZE  in  3  bytes per beat as log2
AWBURST  in  2  burst type; only 2'b01 (INCR) is legal
AWVALID / AWREADY  in / out  1  AW handshake
WDATA  in  DATA_WIDTH  write beat data
WLAST  in  1  last write beat
WVALID / WREADY  in / out  1  W handshake
BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
BVALID / BREADY  out / in  1  B handshake
ARADDR, ARLEN, ARSIZE, ARBURST  in  as AW  read burst attributes
ARVALID / ARREADY  in / out  1  AR handshake
RDATA  out  DATA_WIDTH  read beat data
RRESP  out  2  read response
RLAST  out  1  last read beat
RVALID / RREADY  out / in  1  R handshake
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable (1 = write)
mem_addr  out  MEM_ADDR_WIDTH  memory word index
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read request

Behaviour:
- Reset: when ARESETn=0 at a rising edge, state goes to IDLE. All counters, address registers and rdata_q clear to 0. All VALID/READY outputs, mem_en, mem_we, BRESP, RRESP, RLAST and RDATA are 0 during and after reset until new activity. Reset in the middle of a burst drops the burst with no further mem_en and no B or R response.
- States: IDLE, WR_DATA, WR_RESP, RD_MEM, RD_CAP, RD_DATA.
- IDLE:
  - AWREADY = 1. ARREADY = !AWVALID, so writes have priority when AW and AR are valid in the same cycle.
  - A handshake latches the start address, length, beat_cnt=0 and the error flag, then moves to WR_DATA or RD_MEM.
- Error flag (decided at address handshake):
  - Set if the burst is not INCR.
  - Set if SIZE is not equal to $clog2(DATA_WIDTH/8).
  - Set if the address is unaligned.
  - Set if word_index + LEN is greater than or equal to MEMORY_DEPTH, using a width-extended sum with no wrap.
  - When the flag is set, the whole burst is answered with SLVERR and no mem_en is issued.
- Word index = byte address >> $clog2(DATA_WIDTH/8). The index increments by 1 per beat.
- WR_DATA:
  - WREADY = 1.
  - mem_en = mem_we = WVALID & !err, combinational in the same cycle. mem_addr is the current index and mem_wdata = WDATA.
  - On each beat handshake: beat_cnt and the index increment.
  - A beat where (WLAST != (beat_cnt == len)) sets a sticky wlast_err.
  - On the beat where beat_cnt == len, go to WR_RESP. WLAST is ignored for termination.
- WR_RESP:
  - BVALID = 1. BRESP = SLVERR if err or wlast_err, else OKAY.
  - BREADY=1 returns to IDLE. BVALID is held until then.
- RD_MEM: mem_en = !err, mem_we = 0, mem_addr = current index, for one cycle; then go to RD_CAP.
- RD_CAP: rdata_q <= err ? 0 : mem_rdata; then go to RD_DATA.
- RD_DATA:
  - RVALID = 1, RDATA = rdata_q, RRESP = err ? SLVERR : OKAY, RLAST = (beat_cnt == len).
  - All R outputs stay stable while RREADY=0.
  - On handshake: if last, go to IDLE; else increment beat_cnt and the index and go to RD_MEM.
  - Minimum 3 cycles per read beat.
- mem_en is 0 in all other states. mem_addr and mem_wdata are don't-care when mem_en=0.
- A 256-beat burst (LEN=255) is supported. beat_cnt is 8 bits and never wraps within a burst.

Decomposition:
- Shared package axi4_pkg:
  - burst_t enum: FIXED, INCR, WRAP.
  - resp_t enum: OKAY=2'b00, EXOKAY, SLVERR=2'b10, DECERR.
  - state_t enum for the six states.
  - Constants BYTES_PER_BEAT and ADDR_LSB.
- Single module; no sub-module needed.

Test Plan:
- Write AWADDR=0x0010, LEN=3, SIZE=2, INCR, WDATA=A0..A3 with WLAST on beat 3 -> mem writes at indices 4..7 with A0..A3, one per W handshake; BRESP=OKAY.
- Read ARADDR=0x0010, LEN=3 with RREADY low for 5 cycles on beat 1 -> RDATA=A0..A3, RDATA stable while stalled, RLAST only on beat 3, exactly 4 read mem_en pulses.
- AWVALID and ARVALID high in the same IDLE cycle -> write accepted first, ARREADY=0 until B handshake completes, then read accepted.
- Read ARADDR=(MEMORY_DEPTH-2)*4, LEN=3 -> 4 beats with RRESP=SLVERR, RDATA=0, no mem_en; same for AWBURST=WRAP on a write -> BRESP=SLVERR, no mem writes.
- Write LEN=1 with WLAST on beat 0 -> both beats written, BRESP=SLVERR.
- ARESETn=0 during beat 2 of a 4-beat write -> next cycle all outputs 0 and state IDLE; a following read of index 6 returns the old data.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 types and beat-geometry constants for the memory slave front end.
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_MEM,
        RD_CAP,
        RD_DATA
    } state_t;

    localparam int BUS_DATA_WIDTH = 32;
    localparam int BYTES_PER_BEAT = BUS_DATA_WIDTH / 8;
    localparam int ADDR_LSB       = $clog2(BYTES_PER_BEAT);

    function automatic int addr_lsb_for(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi4_mem_slave_fsm.sv
// AXI4 INCR-burst slave that turns each beat into one single-port memory access.
// One burst in flight; writes win over reads when both address channels are valid.
module axi4_mem_slave_fsm
    import axi4_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int MEMORY_DEPTH   = 1024,
    parameter int MEM_ADDR_WIDTH = $clog2(MEMORY_DEPTH)
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic [7:0]                ARLEN,
    input  logic [2:0]                ARSIZE,
    input  logic [1:0]                ARBURST,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int                    LSB       = addr_lsb_for(DATA_WIDTH);
    localparam logic [2:0]            BEAT_SIZE = 3'(LSB);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'((1 << LSB) - 1);

    state_t                    state;
    logic [MEM_ADDR_WIDTH-1:0] idx;
    logic [7:0]                len;
    logic [7:0]                beat_cnt;
    logic                      err;
    logic                      wlast_err;
    logic                      bvalid_q;
    logic                      rvalid_q;
    logic                      rlast_q;
    resp_t                     bresp_q;
    resp_t                     rresp_q;
    logic [DATA_WIDTH-1:0]     rdata_q;

    logic                  take_wr;
    logic                  take_rd;
    logic                  w_beat;
    logic                  last_beat;
    logic                  wlast_bad;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [7:0]            a_len;
    logic [2:0]            a_size;
    logic [1:0]            a_burst;
    logic [31:0]           a_end;
    logic                  a_err;

    // AWVALID steers the shared attribute mux because a write always wins the IDLE cycle.
    always_comb begin
        a_addr  = AWVALID ? AWADDR  : ARADDR;
        a_len   = AWVALID ? AWLEN   : ARLEN;
        a_size  = AWVALID ? AWSIZE  : ARSIZE;
        a_burst = AWVALID ? AWBURST : ARBURST;
        a_end   = 32'(a_addr >> LSB) + 32'(a_len);
        a_err   = (a_burst != INCR) || (a_size != BEAT_SIZE) ||
                  ((a_addr & ADDR_MASK) != '0) || (a_end >= 32'(MEMORY_DEPTH));
    end

    assign AWREADY   = ARESETn && (state == IDLE);
    assign ARREADY   = ARESETn && (state == IDLE) && !AWVALID;
    assign WREADY    = ARESETn && (state == WR_DATA);
    assign take_wr   = AWVALID && AWREADY;
    assign take_rd   = ARVALID && ARREADY;
    assign w_beat    = WVALID && WREADY;
    assign last_beat = (beat_cnt == len);
    assign wlast_bad = (WLAST != last_beat);

    assign mem_en    = ARESETn && !err &&
                       (((state == WR_DATA) && WVALID) || (state == RD_MEM));
    assign mem_we    = ARESETn && !err && (state == WR_DATA) && WVALID;
    assign mem_addr  = idx;
    assign mem_wdata = WDATA;

    assign BVALID = ARESETn && bvalid_q;
    assign BRESP  = bresp_q;
    assign RVALID = ARESETn && rvalid_q;
    assign RRESP  = rresp_q;
    assign RLAST  = rlast_q;
    assign RDATA  = rdata_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= IDLE;
            idx       <= '0;
            len       <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
            wlast_err <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            bresp_q   <= OKAY;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_wr || take_rd) begin
                        idx       <= MEM_ADDR_WIDTH'(a_addr >> LSB);
                        len       <= a_len;
                        beat_cnt  <= '0;
                        err       <= a_err;
                        wlast_err <= 1'b0;
                        state     <= take_wr ? WR_DATA : RD_MEM;
                    end
                end
                WR_DATA: begin
                    if (w_beat) begin
                        if (wlast_bad) begin
                            wlast_err <= 1'b1;
                        end
                        // Termination follows the beat count; WLAST only feeds the error.
                        if (last_beat) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= (err || wlast_err || wlast_bad) ? SLVERR : OKAY;
                            state    <= WR_RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                            idx      <= idx + 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        bvalid_q <= 1'b0;
                        bresp_q  <= OKAY;
                        state    <= IDLE;
                    end
                end
                RD_MEM: begin
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    rdata_q  <= err ? '0 : mem_rdata;
                    rresp_q  <= err ? SLVERR : OKAY;
                    rlast_q  <= last_beat;
                    rvalid_q <= 1'b1;
                    state    <= RD_DATA;
                end
                RD_DATA: begin
                    if (RREADY) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (last_beat) begin
                            state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                            idx      <= idx + 1'b1;
                            state    <= RD_MEM;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_mem_slave_fsm.sv
// Directed bench for axi4_mem_slave_fsm with a behavioural one-cycle-latency memory.
module tb_axi4_mem_slave_fsm;
    import axi4_pkg::*;

    localparam int LIMIT = 100;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [15:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [15:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    axi4_mem_slave_fsm dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    logic [31:0] mem [0:1023] = '{default: 32'h0};
    logic [9:0]  wr_log_addr [0:63];
    logic [31:0] wr_log_data [0:63];
    int          wr_cnt = 0;
    int          rd_cnt = 0;

    // Behavioural memory plus a log of every write strobe the slave issues.
    always @(posedge ACLK) begin
        if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
            if (wr_cnt < 64) begin
                wr_log_addr[wr_cnt] <= mem_addr;
                wr_log_data[wr_cnt] <= mem_wdata;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= mem[mem_addr];
            rd_cnt    <= rd_cnt + 1;
        end
    end

    int          errors = 0;
    int          checks = 0;
    logic [31:0] rd_data [0:7];
    logic [1:0]  rd_resp [0:7];
    logic        rd_last [0:7];
    logic [31:0] stall_data [0:7];
    logic        stall_valid [0:7];
    logic        abort_mem_en;
    logic        abort_wready;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one write burst; abort_beat >= 0 asserts reset while that beat is offered.
    task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input int wlast_beat, input logic [31:0] base, input int abort_beat,
                            output logic [1:0] resp);
        int n;
        resp = 2'bxx;
        @(negedge ACLK);
        AWADDR = addr; AWLEN = len; AWSIZE = 3'(ADDR_LSB); AWBURST = burst; AWVALID = 1'b1;
        #1;
        n = 0;
        while (AWREADY !== 1'b1 && n < LIMIT) begin @(negedge ACLK); #1; n++; end
        check_output("aw_wait", 32'(n < LIMIT), 32'd1);
        for (int b = 0; b <= int'(len); b++) begin
            @(negedge ACLK);
            AWVALID = 1'b0;
            WDATA = base + 32'(b); WLAST = (b == wlast_beat); WVALID = 1'b1;
            if (b == abort_beat) begin
                ARESETn = 1'b0;
                #1;
                abort_mem_en = mem_en;
                abort_wready = WREADY;
                @(negedge ACLK);
                WVALID = 1'b0; WLAST = 1'b0;
                return;
            end
            #1;
            n = 0;
            while (WREADY !== 1'b1 && n < LIMIT) begin @(negedge ACLK); #1; n++; end
            check_output("w_wait", 32'(n < LIMIT), 32'd1);
        end
        @(negedge ACLK);
        WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
        #1;
        n = 0;
        while (BVALID !== 1'b1 && n < LIMIT) begin @(negedge ACLK); #1; n++; end
        check_output("b_wait", 32'(n < LIMIT), 32'd1);
        resp = BRESP;
        @(negedge ACLK);
        BREADY = 1'b0;
    endtask

    // Reads a burst into rd_data/rd_resp/rd_last, optionally stalling RREADY on one beat.
    task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input int stall_beat, input int stall_cycles);
        int n;
        @(negedge ACLK);
        ARADDR = addr; ARLEN = len; ARSIZE = 3'(ADDR_LSB); ARBURST = burst; ARVALID = 1'b1;
        #1;
        n = 0;
        while (ARREADY !== 1'b1 && n < LIMIT) begin @(negedge ACLK); #1; n++; end
        check_output("ar_wait", 32'(n < LIMIT), 32'd1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            #1;
            n = 0;
            while (RVALID !== 1'b1 && n < LIMIT) begin @(negedge ACLK); #1; n++; end
            check_output("r_wait", 32'(n < LIMIT), 32'd1);
            if (b == stall_beat) begin
                for (int k = 0; k < stall_cycles; k++) begin
                    stall_data[k]  = RDATA;
                    stall_valid[k] = RVALID;
                    @(negedge ACLK);
                    #1;
                end
            end
            if (b < 8) begin
                rd_data[b] = RDATA;
                rd_resp[b] = RRESP;
                rd_last[b] = RLAST;
            end
            RREADY = 1'b1;
            @(negedge ACLK);
            RREADY = 1'b0;
        end
    endtask

    initial begin
        logic [1:0]  resp;
        int          w0;
        int          r0;
        logic [31:0] a_base;
        logic [31:0] b_base;
        a_base = 32'hA5A5_0000;
        b_base = 32'hB0B0_0000;
        ARESETn = 1'b0;
        AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;

        $display("[TB] reset");
        repeat (3) @(negedge ACLK);
        check_output("rst_awready", AWREADY, 0);
        check_output("rst_bvalid",  BVALID,  0);
        check_output("rst_rvalid",  RVALID,  0);
        check_output("rst_mem_en",  mem_en,  0);
        check_output("rst_rdata",   RDATA,   0);
        check_output("rst_rlast",   RLAST,   0);
        check_output("rst_bresp",   BRESP,   0);
        ARESETn = 1'b1;
        #1;
        check_output("idle_awready", AWREADY, 1);
        check_output("idle_arready", ARREADY, 1);

        $display("[TB] write 4 beats at 0x0010");
        w0 = wr_cnt;
        do_write(16'(4 * BYTES_PER_BEAT), 8'd3, 2'b01, 3, a_base, -1, resp);
        check_output("wr1_bresp", resp, 2'b00);
        check_output("wr1_count", wr_cnt - w0, 4);
        for (int i = 0; i < 4; i++) begin
            check_output("wr1_addr", wr_log_addr[w0 + i], 4 + i);
            check_output("wr1_data", wr_log_data[w0 + i], a_base + 32'(i));
        end

        $display("[TB] read 4 beats at 0x0010 with stall on beat 1");
        r0 = rd_cnt;
        do_read(16'h0010, 8'd3, 2'b01, 1, 5);
        for (int i = 0; i < 4; i++) begin
            check_output("rd1_data", rd_data[i], a_base + 32'(i));
            check_output("rd1_resp", rd_resp[i], 2'b00);
            check_output("rd1_last", rd_last[i], (i == 3) ? 1 : 0);
        end
        for (int k = 0; k < 5; k++) begin
            check_output("rd1_stall_data",  stall_data[k],  a_base + 32'd1);
            check_output("rd1_stall_valid", stall_valid[k], 1);
        end
        check_output("rd1_mem_reads", rd_cnt - r0, 4);

        $display("[TB] simultaneous AW and AR");
        @(negedge ACLK);
        AWADDR = 16'h0040; AWLEN = 8'd0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
        ARADDR = 16'h0040; ARLEN = 8'd0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
        #1;
        check_output("prio_awready", AWREADY, 1);
        check_output("prio_arready", ARREADY, 0);
        @(negedge ACLK);
        AWVALID = 1'b0;
        WDATA = 32'hC0C0_C0C0; WLAST = 1'b1; WVALID = 1'b1;
        #1;
        check_output("prio_wready",     WREADY,  1);
        check_output("prio_arready_wd", ARREADY, 0);
        @(negedge ACLK);
        WVALID = 1'b0; WLAST = 1'b0;
        #1;
        check_output("prio_bvalid",     BVALID,  1);
        check_output("prio_arready_wr", ARREADY, 0);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        #1;
        check_output("prio_arready_idle", ARREADY, 1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        repeat (2) @(negedge ACLK);
        #1;
        check_output("prio_rvalid", RVALID, 1);
        check_output("prio_rdata",  RDATA,  32'hC0C0_C0C0);
        check_output("prio_rlast",  RLAST,  1);
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;

        $display("[TB] out-of-range read and WRAP write");
        r0 = rd_cnt;
        do_read(16'h0FF8, 8'd3, 2'b01, -1, 0);
        for (int i = 0; i < 4; i++) begin
            check_output("oor_resp", rd_resp[i], 2'b10);
            check_output("oor_data", rd_data[i], 0);
            check_output("oor_last", rd_last[i], (i == 3) ? 1 : 0);
        end
        check_output("oor_mem_reads", rd_cnt - r0, 0);
        w0 = wr_cnt;
        do_write(16'h0020, 8'd1, 2'b10, 1, 32'hDEAD_0000, -1, resp);
        check_output("wrap_bresp",  resp,        2'b10);
        check_output("wrap_writes", wr_cnt - w0, 0);

        $display("[TB] early WLAST");
        w0 = wr_cnt;
        do_write(16'h0030, 8'd1, 2'b01, 0, 32'hD000_0000, -1, resp);
        check_output("wlast_bresp",  resp,        2'b10);
        check_output("wlast_writes", wr_cnt - w0, 2);
        check_output("wlast_addr1",  wr_log_addr[w0 + 1], 13);
        check_output("wlast_data1",  wr_log_data[w0 + 1], 32'hD000_0001);

        $display("[TB] reset during beat 2 of a write");
        w0 = wr_cnt;
        do_write(16'h0010, 8'd3, 2'b01, 3, b_base, 2, resp);
        check_output("abort_mem_en_in_rst", abort_mem_en, 0);
        check_output("abort_wready_in_rst", abort_wready, 0);
        check_output("abort_writes",        wr_cnt - w0,  2);
        check_output("abort_awready",       AWREADY,      0);
        check_output("abort_wready",        WREADY,       0);
        check_output("abort_bvalid",        BVALID,       0);
        check_output("abort_rvalid",        RVALID,       0);
        check_output("abort_mem_en",        mem_en,       0);
        check_output("abort_rdata",         RDATA,        0);
        ARESETn = 1'b1;
        #1;
        check_output("abort_idle_awready", AWREADY, 1);
        do_read(16'h0018, 8'd0, 2'b01, -1, 0);
        check_output("abort_old_data", rd_data[0], a_base + 32'd2);
        check_output("abort_old_resp", rd_resp[0], 2'b00);
        check_output("abort_no_b",     BVALID,     0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
